// File: rtl/preamble_stf_gen.sv
// Purpose: generates one 802.11 L-STF burst of 16*N I/Q samples from an internal 16-entry table.
// Latency: first sample is valid the cycle after start is accepted in IDLE; one sample per handshake.
// Backpressure: out_ready low stalls the burst; all outputs are registered and hold while stalled.
module preamble_stf_gen #(
  parameter int IQ_WIDTH    = 16,
  parameter int DEFAULT_REP = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [3:0]          num_rep,
  input  logic                win_en,
  output logic [IQ_WIDTH-1:0] out_i,
  output logic [IQ_WIDTH-1:0] out_q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int         SHIFT   = 16 - IQ_WIDTH;
  localparam logic [3:0] DEF_REP = 4'(DEFAULT_REP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [3:0]          idx, idx_nxt;
  logic [3:0]          per, per_nxt;
  logic [3:0]          rep_q, rep_nxt;
  logic                win_q, win_nxt;
  logic [IQ_WIDTH-1:0] i_nxt, q_nxt;
  logic                valid_nxt, last_nxt, busy_nxt, done_nxt;
  logic                hs;
  logic [3:0]          eff_rep;
  logic [3:0]          adv_idx, adv_per;
  logic                adv_last;
  logic [31:0]         adv_entry, first_entry;

  // The table only has 8 distinct entries; indices 8..15 repeat 0..7.
  function automatic logic [31:0] stf_entry(input logic [2:0] k);
    case (k)
      3'd0:    stf_entry = {16'hfd0e, 16'hfd0e};
      3'd1:    stf_entry = {16'hfbd6, 16'h0000};
      3'd2:    stf_entry = {16'hfd0e, 16'h02f2};
      3'd3:    stf_entry = {16'h0000, 16'h042a};
      3'd4:    stf_entry = {16'h02f2, 16'h02f2};
      3'd5:    stf_entry = {16'h042a, 16'h0000};
      3'd6:    stf_entry = {16'h02f2, 16'hfd0e};
      default: stf_entry = {16'h0000, 16'hfbd6};
    endcase
  endfunction

  // Floor scaling to the output width, with an optional extra halving for the window edges.
  function automatic logic [IQ_WIDTH-1:0] scale(input logic [15:0] v, input logic half);
    logic signed [15:0] s;
    s = $signed(v) >>> SHIFT;
    if (half) begin
      s = s >>> 1;
    end
    scale = s[IQ_WIDTH-1:0];
  endfunction

  assign hs          = out_valid & out_ready;
  assign eff_rep     = (rep_q == 4'd0) ? DEF_REP : rep_q;
  assign adv_idx     = idx + 4'd1;
  assign adv_per     = (idx == 4'hf) ? per + 4'd1 : per;
  assign adv_last    = (adv_idx == 4'hf) && (adv_per == eff_rep - 4'd1);
  assign adv_entry   = stf_entry(adv_idx[2:0]);
  assign first_entry = stf_entry(3'd0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only matters in IDLE; a burst ends on the handshake of its last beat.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (hs && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath next values: pre-compute the sample the registers will present next.
  always_comb begin
    idx_nxt   = idx;
    per_nxt   = per;
    rep_nxt   = rep_q;
    win_nxt   = win_q;
    i_nxt     = out_i;
    q_nxt     = out_q;
    valid_nxt = out_valid;
    last_nxt  = out_last;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        if (start) begin
          rep_nxt   = num_rep;
          win_nxt   = win_en;
          idx_nxt   = 4'd0;
          per_nxt   = 4'd0;
          i_nxt     = scale(first_entry[31:16], win_en);
          q_nxt     = scale(first_entry[15:0], win_en);
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
        end
      end
      RUN: begin
        if (hs) begin
          if (out_last) begin
            idx_nxt   = 4'd0;
            per_nxt   = 4'd0;
            valid_nxt = 1'b0;
            last_nxt  = 1'b0;
          end else begin
            idx_nxt   = adv_idx;
            per_nxt   = adv_per;
            i_nxt     = scale(adv_entry[31:16], win_q & adv_last);
            q_nxt     = scale(adv_entry[15:0], win_q & adv_last);
            valid_nxt = 1'b1;
            last_nxt  = adv_last;
          end
        end
      end
      default: begin
        idx_nxt   = 4'd0;
        per_nxt   = 4'd0;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // Datapath and output registers; reset clears everything including the latched burst settings.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= 4'd0;
      per       <= 4'd0;
      rep_q     <= 4'd0;
      win_q     <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      idx       <= idx_nxt;
      per       <= per_nxt;
      rep_q     <= rep_nxt;
      win_q     <= win_nxt;
      out_i     <= i_nxt;
      out_q     <= q_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: doc/preamble_stf_gen.md
PREAMBLE_STF_GEN -- requirements
Module: preamble_stf_gen

Interface
REQ-001 SHALL have parameter IQ_WIDTH, default 16, output sample width per I/Q component; legal range 8..16.
REQ-002 SHALL have parameter DEFAULT_REP, default 10, number of 16-sample periods used when num_rep = 0; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to begin one L-STF burst; sampled in IDLE only.
REQ-006 SHALL have port num_rep  input  4  period count (1..15), latched on accepted start; 0 selects DEFAULT_REP.
REQ-007 SHALL have port win_en  input  1  halve first and last burst samples; latched on accepted start.
REQ-008 SHALL have port out_i  output  IQ_WIDTH  signed in-phase sample.
REQ-009 SHALL have port out_q  output  IQ_WIDTH  signed quadrature sample.
REQ-010 SHALL have port out_valid  output  1  out_i/out_q/out_last hold a valid sample.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the sample when out_valid is high.
REQ-012 SHALL have port out_last  output  1  marks the final sample of the burst.
REQ-013 SHALL have port busy  output  1  high from accepted start until the cycle done pulses.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the final handshake.

Function
REQ-015 SHALL hold an internal 16-entry table of 16-bit signed (I,Q) pairs, index 0..15: (fd0e,fd0e) (fbd6,0000) (fd0e,02f2) (0000,042a) (02f2,02f2) (042a,0000) (02f2,fd0e) (0000,fbd6), then indices 8..15 repeat indices 0..7.
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE->RUN on start=1.
- RUN->DONE on handshake (out_valid & out_ready) with out_last=1.
- DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL ignore start in RUN and DONE; no restart and no change to latched num_rep or win_en.
REQ-018 SHALL assert out_valid with table index 0 of period 0 in the cycle after start is sampled in IDLE (latency 1).
REQ-019 SHALL use a 4-bit sample index and a 4-bit period counter, both advancing only on handshake.
- Sample index wraps 15->0.
- Period counter increments on that wrap.
REQ-020 SHALL emit exactly 16*N samples per burst, where N is the effective rep count.
REQ-021 SHALL assert out_last only for index 15 of period N-1.
REQ-022 SHALL hold out_i, out_q, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL keep out_valid continuously high in RUN, so one sample transfers per cycle when out_ready=1.
REQ-024 SHALL scale each component as the table value arithmetically right-shifted by (16-IQ_WIDTH), rounding by floor (truncation toward minus infinity).
REQ-025 SHALL, when latched win_en=1, additionally arithmetic-shift the first and last burst samples right by 1 after the REQ-024 scaling; all other samples are unaffected.
REQ-026 SHALL drive all outputs from registers, with no combinational path from out_ready to out_valid or to the data outputs.
REQ-027 SHALL drive out_valid=0 and out_last=0 in IDLE and DONE; out_i/out_q are don't-care while out_valid=0 but SHALL be 0 after reset.
REQ-028 SHALL assert busy in RUN and DONE, and pulse done for exactly the DONE cycle.
REQ-029 SHALL accept start in the IDLE cycle immediately following DONE.

Reset
REQ-030 SHALL, on reset=1 at any time including mid-burst, asynchronously force state=IDLE, counters=0, out_valid=0, out_last=0, busy=0, done=0, out_i=0, out_q=0, latched num_rep=0 and latched win_en=0.
REQ-031 SHALL require a new start after reset deasserts; an interrupted burst SHALL NOT resume.

Verification
REQ-032 SHALL verify the default burst: IQ_WIDTH=16, num_rep=0, win_en=0, out_ready=1, start pulse -> 160 consecutive beats; beat0=(fd0e,fd0e), beat17=(fbd6,0000), beat159=(0000,fbd6) with out_last=1; done pulses once, one cycle after beat159.
REQ-033 SHALL verify windowing: num_rep=2, win_en=1 -> 32 beats; beat0=(fe87,fe87), beat31=(0000,fdeb), beat1=(fbd6,0000) unmodified.
REQ-034 SHALL verify width scaling: IQ_WIDTH=12, num_rep=1 -> 16 beats; beat0=(fd0,fd0), beat3=(000,042), beat5=(042,000).
REQ-035 SHALL verify backpressure: random out_ready at 50% -> sequence identical to REQ-032, and data stable during every stall cycle.
REQ-036 SHALL verify ignored start: start re-pulsed during RUN with num_rep=3 -> the burst still ends after the original count.
REQ-037 SHALL verify reset mid-burst: reset asserted at beat 40 -> out_valid=0 and busy=0 immediately; a new start yields beat0=(fd0e,fd0e).
